// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - borrow_in LSB-first through one full-subtractor cell,
// one bit per clock, with valid/ready handshakes on both the operand and result sides.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int unsigned    CntW    = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic              br_q, br_d;
    logic              bout_q, bout_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic              d_bit;
    logic              br_next;
    logic [WIDTH-1:0]  res_shift;

    // Full-subtractor cell on the current LSBs.
    always_comb begin
        d_bit     = a_q[0] ^ b_q[0] ^ br_q;
        br_next   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        res_shift = res_q >> 1;
        res_shift[WIDTH-1] = d_bit;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        br_d    = br_q;
        bout_d  = bout_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = borrow_in;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = br_next;
                res_d = res_shift;
                cnt_d = cnt_q + CntW'(1);
                // Output regs load only on the final bit so no partial result ever shows.
                if (cnt_q == LastCnt) begin
                    diff_d  = res_shift;
                    bout_d  = br_next;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready   = (state_q == StIdle);
    assign out_valid  = (state_q == StDone);
    assign diff       = diff_q;
    assign borrow_out = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive checks of serial_subtractor at WIDTH = 8, 4 and 1.
module tb_serial_subtractor;

    logic clk;
    logic rstn;

    logic       in_valid8, in_ready8, bin8, out_valid8, out_ready8, bout8;
    logic [7:0] a8, b8, diff8;

    logic       in_valid4, in_ready4, bin4, out_valid4, bout4;
    logic [3:0] a4, b4, diff4;

    logic       in_valid1, in_ready1, bin1, out_valid1, bout1;
    logic [0:0] a1, b1, diff1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] diff;
        logic       bout;
    } vec_t;

    vec_t vecs[8];

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
        .borrow_in(bin8), .out_valid(out_valid8), .out_ready(out_ready8), .diff(diff8),
        .borrow_out(bout8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
        .borrow_in(bin4), .out_valid(out_valid4), .out_ready(1'b1), .diff(diff4),
        .borrow_out(bout4)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
        .borrow_in(bin1), .out_valid(out_valid1), .out_ready(1'b1), .diff(diff1),
        .borrow_out(bout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Capture one operand set on dut8 and return clocks from capture edge to out_valid.
    task automatic start8(input logic [7:0] ai, input logic [7:0] bi, input logic bini,
                          output int lat);
        @(negedge clk);
        a8 = ai; b8 = bi; bin8 = bini; in_valid8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid8 = 1'b0;
        a8 = 8'hXX; b8 = 8'hXX;
        lat = 0;
        while (!out_valid8 && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic op8(input string name, input logic [7:0] ai, input logic [7:0] bi,
                       input logic bini, input logic [7:0] ed, input logic eb);
        int lat;
        chk({name, "_in_ready"}, in_ready8, 1'b1);
        start8(ai, bi, bini, lat);
        chk({name, "_latency"}, lat, 8);
        chk({name, "_diff"}, diff8, ed);
        chk({name, "_bout"}, bout8, eb);
        out_ready8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready8 = 1'b0;
        chk({name, "_back_idle"}, {in_ready8, out_valid8}, 2'b10);
    endtask

    initial begin
        int lat;
        int e;

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
        vecs[2] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};
        vecs[4] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};
        vecs[5] = '{8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0};
        vecs[6] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
        vecs[7] = '{8'hC8, 8'h64, 1'b1, 8'h63, 1'b0};

        in_valid8 = 0; out_ready8 = 0; a8 = 0; b8 = 0; bin8 = 0;
        in_valid4 = 0; a4 = 0; b4 = 0; bin4 = 0;
        in_valid1 = 0; a1 = 0; b1 = 0; bin1 = 0;
        rstn = 1'b1;
        #1 rstn = 1'b0;
        #1;
        chk("reset_outputs", {in_ready8, out_valid8, bout8, diff8}, {1'b1, 1'b0, 1'b0, 8'h00});
        #20 rstn = 1'b1;
        @(negedge clk);
        chk("reset_idle", {in_ready8, out_valid8}, 2'b10);

        for (int i = 0; i < 8; i++) begin
            op8($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].diff,
                vecs[i].bout);
        end

        // Result stall with ignored in_valid pulses.
        start8(8'h33, 8'h11, 1'b0, lat);
        chk("stall_latency", lat, 8);
        for (int i = 0; i < 5; i++) begin
            in_valid8 = ~in_valid8;
            a8 = 8'hEE; b8 = 8'h01;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("stall%0d", i), {out_valid8, in_ready8, bout8, diff8},
                {1'b1, 1'b0, 1'b0, 8'h22});
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready8 = 1'b0;
        chk("stall_release", {in_ready8, out_valid8, diff8}, {1'b1, 1'b0, 8'h22});
        @(posedge clk);
        @(negedge clk);
        chk("idle_no_restart", {in_ready8, out_valid8}, 2'b10);

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        a8 = 8'h55; b8 = 8'h22; bin8 = 1'b0; in_valid8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid8 = 1'b0;
        repeat (4) @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("midrun_reset", {out_valid8, in_ready8, bout8, diff8}, {1'b0, 1'b1, 1'b0, 8'h00});
        @(negedge clk);
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        chk("after_reset_quiet", {out_valid8, in_ready8}, 2'b01);
        op8("post_reset", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0);

        // Exhaustive WIDTH=4 against an integer reference.
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int bn = 0; bn < 2; bn++) begin
                    @(negedge clk);
                    a4 = 4'(ai); b4 = 4'(bi); bin4 = bn[0]; in_valid4 = 1'b1;
                    @(posedge clk);
                    @(negedge clk);
                    in_valid4 = 1'b0;
                    lat = 0;
                    while (!out_valid4 && lat < 12) begin
                        @(posedge clk);
                        lat++;
                        @(negedge clk);
                    end
                    e = ai - bi - bn;
                    chk($sformatf("w4_%0d_%0d_%0d", ai, bi, bn), {lat[7:0], bout4, diff4},
                        {8'd4, (e < 0) ? 1'b1 : 1'b0, 4'(e & 15)});
                    @(posedge clk);
                end
            end
        end

        // WIDTH=1: full-subtractor truth table, one-clock latency.
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            a1 = k[2]; b1 = k[1]; bin1 = k[0]; in_valid1 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid1 = 1'b0;
            lat = 0;
            while (!out_valid1 && lat < 6) begin
                @(posedge clk);
                lat++;
                @(negedge clk);
            end
            e = int'(k[2]) - int'(k[1]) - int'(k[0]);
            chk($sformatf("w1_%0d", k), {lat[7:0], bout1, diff1},
                {8'd1, (e < 0) ? 1'b1 : 1'b0, 1'(e & 1)});
            @(posedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
